bit_serial_adder_ctrl: RTL and testbench



---
 rtl/bit_serial_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 13 +
 rtl/bit_serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_bit_serial_adder_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; WIDTH+1 keeps a legal width of 1 when WIDTH is 1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder reused once per clock by the serial controller.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, start/busy/done handshake.
// Optional signed overflow output is built when BIT_SERIAL_ADD_OVF_EN is defined.
module bit_serial_adder_ctrl
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_sh_next;

    full_adder_cell u_cell (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_sh_next = w_s;
        end else begin : g_wn
            assign w_sum_sh_next = {w_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_sh_next;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Result registers load on the edge into DONE so they are valid with done.
                        r_sum   <= w_sum_sh_next;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIT_SERIAL_ADD_OVF_EN
    logic r_ovf;

    // During the last RUN cycle r_carry is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_bit_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic       ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned sum; overflow from operand/result signs.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
        logic [8:0] tot;
        logic       v;
        tot = {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
`ifdef BIT_SERIAL_ADD_OVF_EN
        v = (ma[7] == mb[7]) && (tot[7] != ma[7]);
`else
        v = 1'b0;
`endif
        return {v, tot};
    endfunction

    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        logic [9:0] exp;
        exp = model(ta, tb_, tc);
        check("idle_busy", {31'd0, busy}, 32'd0);
        a = ta;
        b = tb_;
        cin = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check("run_busy", {31'd0, busy}, 32'd1);
            check("run_done", {31'd0, done}, 32'd0);
            tick();
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("sum", {24'd0, sum}, {24'd0, exp[7:0]});
        check("cout", {31'd0, cout}, {31'd0, exp[8]});
        check("ovf", {31'd0, ovf}, {31'd0, exp[9]});
        $display("txn a=%h b=%h cin=%b sum=%h cout=%b ovf=%b", ta, tb_, tc, sum, cout, ovf);
        start = 1'b1;
        tick();
        check("done_clears", {31'd0, done}, 32'd0);
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        check("sum_held", {24'd0, sum}, {24'd0, exp[7:0]});
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cin1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);

        run_add(8'h05, 8'h03, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0);
        run_add(8'h00, 8'h00, 1'b1);
        run_add(8'h7F, 8'h01, 1'b0);
        run_add(8'h80, 8'h80, 1'b0);
        for (int n = 0; n < 20; n++) begin
            run_add(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // start held high: one result every WIDTH+2 cycles, operands disturbed mid-RUN
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            check("cont_done", {31'd0, done}, {31'd0, (cyc % 10) == 9});
            if ((cyc % 10) == 9) begin
                check("cont_sum", {24'd0, sum}, 32'h30);
                $display("txn cont a=10 b=20 sum=%h cout=%b", sum, cout);
            end
            if ((cyc % 10) == 3) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            if ((cyc % 10) == 8) begin
                a = 8'h10;
                b = 8'h20;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // WIDTH=1 instance
        a1 = 1'b1;
        b1 = 1'b1;
        cin1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        check("w1_run_done", {31'd0, done1}, 32'd0);
        tick();
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_busy_off", {31'd0, busy1}, 32'd0);
        check("w1_sum", {31'd0, sum1}, 32'd1);
        check("w1_cout", {31'd0, cout1}, 32'd1);
        check("w1_ovf", {31'd0, ovf1}, 32'd0);
        $display("txn w1 a=1 b=1 cin=1 sum=%b cout=%b", sum1, cout1);
        tick();
        check("w1_done_clears", {31'd0, done1}, 32'd0);

        // reset in cycle 4 of RUN aborts the operation
        a = 8'h33;
        b = 8'h44;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        $display("txn abort a=33 b=44 sum=%h", sum);
        run_add(8'h0A, 8'h05, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
